// File: rtl/pcs_pkg.sv
// Shared types and constants for the PCS transmit path.
// Used by the transmit sequencer and its alignment-marker scheduler.
package pcs_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRST_AM = 2'd1,
        RUN      = 2'd2
    } pcs_tx_ctrl_state_e;

    localparam int unsigned GEARBOX_PERIOD  = 33;
    localparam int unsigned AM_INTERVAL_40G = 16383;

endpackage

// File: rtl/pcs_tx_ctrl_if.sv
// Handshake bundle between the MAC-side controller and the transmit sequencer.
// The slave side is the sequencer; the master side enables the link and observes the strobes.
interface pcs_tx_ctrl_if #(
    parameter int SEQ_W = 6
);
    logic             en_i;
    logic [SEQ_W-1:0] seq_o;
    logic             gearbox_full_o;
    logic             marker_v_o;
    logic             ready_o;

    modport master (
        output en_i,
        input  seq_o,
        input  gearbox_full_o,
        input  marker_v_o,
        input  ready_o
    );

    modport slave (
        input  en_i,
        output seq_o,
        output gearbox_full_o,
        output marker_v_o,
        output ready_o
    );
endinterface

// File: rtl/pcs_am_sched.sv
// Alignment-marker scheduler: counts accepted data blocks and claims a block
// slot for an AM once AM_INTERVAL blocks have gone out, deferring past gearbox pauses.
module pcs_am_sched #(
    parameter int AM_INTERVAL = 16383,
    parameter int AM_CNT_W    = $clog2(AM_INTERVAL + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    input  logic full,
    input  logic first,
    output logic marker_v,
    output logic slot_free
);

    logic [AM_CNT_W-1:0] am_cnt_r;
    logic                am_due_s;

    assign am_due_s  = (am_cnt_r == AM_CNT_W'(AM_INTERVAL));
    assign marker_v  = first || (run && !full && am_due_s);
    assign slot_free = run && !full && !am_due_s;

    // AM counter: cleared by a marker or by leaving the active states, held over pauses.
    always_ff @(posedge clk) begin
        if (reset) begin
            am_cnt_r <= {AM_CNT_W{1'b0}};
        end else if (clr || first || !run) begin
            am_cnt_r <= {AM_CNT_W{1'b0}};
        end else if (full) begin
            am_cnt_r <= am_cnt_r;
        end else if (am_due_s) begin
            am_cnt_r <= {AM_CNT_W{1'b0}};
        end else begin
            am_cnt_r <= am_cnt_r + {{(AM_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pcs_tx_ctrl.sv
// PCS transmit sequencer: runs the gearbox sequence counter and decides per cycle
// whether a MAC block is accepted, a gearbox pause is taken, or an AM slot is used.
module pcs_tx_ctrl
    import pcs_pkg::*;
#(
    parameter int IS_10G      = 0,
    parameter int DATA_W      = 64,
    parameter int HEAD_W      = 2,
    parameter int SEQ_W       = $clog2(DATA_W / HEAD_W + 1),
    parameter int AM_INTERVAL = AM_INTERVAL_40G,
    parameter int AM_CNT_W    = $clog2(AM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          reset,
    pcs_tx_ctrl_if.slave  bus
);

    localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(DATA_W / HEAD_W);

    pcs_tx_ctrl_state_e state_r;
    logic [SEQ_W-1:0]   seq_r;
    logic [SEQ_W-1:0]   seq_nxt_s;
    logic               run_s;
    logic               first_s;
    logic               full_s;
    logic               marker_v_s;
    logic               slot_free_s;

    assign run_s   = (state_r == RUN);
    assign first_s = (state_r == FIRST_AM);
    assign full_s  = (state_r != IDLE) && (seq_r == SEQ_LAST);

    // Gearbox sequence wraps after the pause slot.
    always_comb begin
        seq_nxt_s = {SEQ_W{1'b0}};
        if (seq_r == SEQ_LAST) begin
            seq_nxt_s = {SEQ_W{1'b0}};
        end else begin
            seq_nxt_s = seq_r + {{(SEQ_W-1){1'b0}}, 1'b1};
        end
    end

    // Link FSM and sequence counter; dropping en_i returns to IDLE with seq cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            seq_r   <= {SEQ_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    seq_r <= {SEQ_W{1'b0}};
                    if (bus.en_i) begin
                        state_r <= (IS_10G != 0) ? RUN : FIRST_AM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FIRST_AM, RUN: begin
                    if (!bus.en_i) begin
                        state_r <= IDLE;
                        seq_r   <= {SEQ_W{1'b0}};
                    end else begin
                        state_r <= RUN;
                        seq_r   <= seq_nxt_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    seq_r   <= {SEQ_W{1'b0}};
                end
            endcase
        end
    end

    generate
        if (IS_10G == 0) begin : g_am
            pcs_am_sched #(
                .AM_INTERVAL (AM_INTERVAL),
                .AM_CNT_W    (AM_CNT_W)
            ) u_am_sched (
                .clk       (clk),
                .reset     (reset),
                .clr       (!bus.en_i),
                .run       (run_s),
                .full      (full_s),
                .first     (first_s),
                .marker_v  (marker_v_s),
                .slot_free (slot_free_s)
            );
        end else begin : g_no_am
            assign marker_v_s  = 1'b0;
            assign slot_free_s = run_s && !full_s;
        end
    endgenerate

    assign bus.seq_o          = seq_r;
    assign bus.gearbox_full_o = full_s;
    assign bus.marker_v_o     = marker_v_s;
    assign bus.ready_o        = slot_free_s;

endmodule

// File: tb/tb_pcs_tx_ctrl.sv
// Bench for pcs_tx_ctrl: a 10G instance and two 40G instances (AM every 5 and 31 blocks)
// share stimulus and are compared each cycle against a cycle-count based reference model.
module tb_pcs_tx_ctrl;
    import pcs_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pcs_tx_ctrl_if #(.SEQ_W(6)) bus0 ();
    pcs_tx_ctrl_if #(.SEQ_W(6)) bus1 ();
    pcs_tx_ctrl_if #(.SEQ_W(6)) bus2 ();

    pcs_tx_ctrl #(.IS_10G(1), .AM_INTERVAL(5))  dut0 (.clk(clk), .reset(reset), .bus(bus0));
    pcs_tx_ctrl #(.IS_10G(0), .AM_INTERVAL(5))  dut1 (.clk(clk), .reset(reset), .bus(bus1));
    pcs_tx_ctrl #(.IS_10G(0), .AM_INTERVAL(31)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    logic [5:0] seq_a  [N];
    logic       full_a [N];
    logic       mk_a   [N];
    logic       rd_a   [N];

    assign seq_a[0] = bus0.seq_o;  assign full_a[0] = bus0.gearbox_full_o;
    assign mk_a[0]  = bus0.marker_v_o; assign rd_a[0] = bus0.ready_o;
    assign seq_a[1] = bus1.seq_o;  assign full_a[1] = bus1.gearbox_full_o;
    assign mk_a[1]  = bus1.marker_v_o; assign rd_a[1] = bus1.ready_o;
    assign seq_a[2] = bus2.seq_o;  assign full_a[2] = bus2.gearbox_full_o;
    assign mk_a[2]  = bus2.marker_v_o; assign rd_a[2] = bus2.ready_o;

    // Reference model: cycles since enable, and blocks sent since the last AM.
    bit          is40    [N] = '{1'b0, 1'b1, 1'b1};
    int          am_int  [N] = '{0, 5, 31};
    bit          active  [N];
    int          t_en    [N];
    int          blk     [N];
    bit          exp_mk  [N];
    bit          exp_rd  [N];
    int          gap_cnt [N];
    bit          had_mk  [N];

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic en_v, input logic rst_v);
        int seq_e;
        bit full_e;
        reset = rst_v;
        bus0.en_i = en_v;
        bus1.en_i = en_v;
        bus2.en_i = en_v;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (exp_mk[i]) blk[i] = 0;
            else if (exp_rd[i]) blk[i] = blk[i] + 1;
            if (rst_v || !en_v) begin
                active[i] = 1'b0;
                blk[i]    = 0;
                had_mk[i] = 1'b0;
                gap_cnt[i] = 0;
            end else if (!active[i]) begin
                active[i] = 1'b1;
                t_en[i]   = 0;
            end else begin
                t_en[i] = t_en[i] + 1;
            end

            seq_e     = 0;
            full_e    = 1'b0;
            exp_mk[i] = 1'b0;
            exp_rd[i] = 1'b0;
            if (active[i]) begin
                seq_e  = t_en[i] % GEARBOX_PERIOD;
                full_e = (seq_e == GEARBOX_PERIOD - 1);
                if (is40[i] && t_en[i] == 0) exp_mk[i] = 1'b1;
                else if (full_e) exp_mk[i] = 1'b0;
                else if (is40[i] && blk[i] == am_int[i]) exp_mk[i] = 1'b1;
                else exp_rd[i] = 1'b1;
            end

            chk($sformatf("seq[%0d]", i),   int'(seq_a[i]),  seq_e);
            chk($sformatf("full[%0d]", i),  int'(full_a[i]), int'(full_e));
            chk($sformatf("mk[%0d]", i),    int'(mk_a[i]),   int'(exp_mk[i]));
            chk($sformatf("rdy[%0d]", i),   int'(rd_a[i]),   int'(exp_rd[i]));
            chk($sformatf("excl[%0d]", i),
                int'((int'(mk_a[i]) + int'(rd_a[i]) + int'(full_a[i])) <= 1), 1);

            // Observed data blocks between consecutive AMs within one enabled run.
            if (is40[i]) begin
                if (mk_a[i] === 1'b1) begin
                    if (had_mk[i]) chk($sformatf("am_gap[%0d]", i), gap_cnt[i], am_int[i]);
                    had_mk[i]  = 1'b1;
                    gap_cnt[i] = 0;
                end else if (rd_a[i] === 1'b1) begin
                    gap_cnt[i] = gap_cnt[i] + 1;
                end
            end
        end
    endtask

    initial begin
        bit en_r;
        bit found;
        reset = 1'b1;
        bus0.en_i = 1'b0;
        bus1.en_i = 1'b0;
        bus2.en_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            active[i] = 1'b0; t_en[i] = 0; blk[i] = 0;
            exp_mk[i] = 1'b0; exp_rd[i] = 1'b0; gap_cnt[i] = 0; had_mk[i] = 1'b0;
        end

        // Reset held with en_i high, then release and run several gearbox periods.
        repeat (3) step(1'b1, 1'b1);
        repeat (120) step(1'b1, 1'b0);

        // Drop en_i at seq 17, then re-enable.
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (t_en[0] % GEARBOX_PERIOD == 17) found = 1'b1;
            else step(1'b1, 1'b0);
        end
        chk("reach_seq17", int'(found), 1);
        step(1'b0, 1'b0);
        repeat (80) step(1'b1, 1'b0);

        // Random enable/reset activity with long enabled stretches.
        en_r = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 149) == 0) en_r = ~en_r;
            if (!en_r && $urandom_range(0, 3) == 0) en_r = 1'b1;
            step(en_r, ($urandom_range(0, 599) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
